// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: line codes, error-bit positions
// and the configuration sequencer state type.
package uart_pkg;

    localparam logic [1:0] Baud9600   = 2'b00;
    localparam logic [1:0] Baud19200  = 2'b01;
    localparam logic [1:0] Baud57600  = 2'b10;
    localparam logic [1:0] Baud115200 = 2'b11;

    localparam logic [1:0] ParityNone = 2'b00;
    localparam logic [1:0] ParityOdd  = 2'b01;
    localparam logic [1:0] ParityEven = 2'b10;

    localparam int unsigned ErrParityBit = 0;
    localparam int unsigned ErrStartBit  = 1;
    localparam int unsigned ErrStopBit   = 2;
    localparam int unsigned ErrW         = 3;
    localparam int unsigned DataW        = 8;

    typedef enum logic [0:0] {
        CfgIdle,
        CfgWait
    } cfgState_e;

    function automatic logic hasError(input logic [ErrW-1:0] err);
        return |err;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding completed receive frames. Pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Push,
    input  logic [WIDTH-1:0] PushData,
    input  logic             Pop,
    output logic [WIDTH-1:0] PopData,
    output logic             Full,
    output logic             Empty
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
    logic             doPush, doPop;

    assign Empty = (wrPtrQ == rdPtrQ);
    assign Full  = (wrPtrQ[PtrW-1] != rdPtrQ[PtrW-1]) &&
                   (wrPtrQ[IdxW-1:0] == rdPtrQ[IdxW-1:0]);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign doPop  = Pop && !Empty;
    assign doPush = Push && (!Full || doPop);

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
            if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtrQ[IdxW-1:0]] <= PushData;
    end

    assign PopData = Empty ? '0 : mem[rdPtrQ[IdxW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: defers baud/parity changes to frame gaps, buffers
// received frames with their error flags, and tracks overrun and error counts.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 8,
    parameter logic [1:0]  RESET_BAUD   = 2'b00,
    parameter logic [1:0]  RESET_PARITY = 2'b00
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             CfgWrite,
    input  logic [1:0]       CfgBaud,
    input  logic [1:0]       CfgParity,
    output logic             CfgBusy,
    output logic [1:0]       BaudRate,
    output logic [1:0]       ParityType,
    input  logic             RxActive,
    input  logic             RxDone,
    input  logic [DataW-1:0] RxData,
    input  logic [ErrW-1:0]  RxError,
    output logic             OutValid,
    output logic [DataW-1:0] OutData,
    output logic [ErrW-1:0]  OutError,
    input  logic             OutReady,
    output logic             Overrun,
    output logic [CNT_W-1:0] ErrCount,
    input  logic             ClearStatus
);

    localparam int unsigned EntryW = ErrW + DataW;

    cfgState_e  stateQ, stateD;
    logic [3:0] shadowQ, shadowD;
    logic       commit;

    always_comb begin
        stateD  = stateQ;
        shadowD = shadowQ;
        commit  = 1'b0;
        unique case (stateQ)
            CfgIdle: begin
                if (CfgWrite) begin
                    shadowD = {CfgBaud, CfgParity};
                    stateD  = CfgWait;
                end
            end
            CfgWait: begin
                if (CfgWrite) begin
                    shadowD = {CfgBaud, CfgParity};
                end else if (!RxActive && !RxDone) begin
                    // Only a quiet line cycle is a safe point to retune the receiver.
                    commit = 1'b1;
                    stateD = CfgIdle;
                end
            end
            default: stateD = CfgIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            stateQ     <= CfgIdle;
            shadowQ    <= '0;
            BaudRate   <= RESET_BAUD;
            ParityType <= RESET_PARITY;
        end else begin
            stateQ  <= stateD;
            shadowQ <= shadowD;
            if (commit) begin
                BaudRate   <= shadowQ[3:2];
                ParityType <= shadowQ[1:0];
            end
        end
    end

    assign CfgBusy = (stateQ == CfgWait);

    logic              fifoFull, fifoEmpty, pop;
    logic [EntryW-1:0] headEntry;

    assign pop      = OutValid && OutReady;
    assign OutValid = !fifoEmpty;
    assign OutData  = headEntry[DataW-1:0];
    assign OutError = headEntry[EntryW-1:DataW];

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) uFifo (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .Push     (RxDone),
        .PushData ({RxError, RxData}),
        .Pop      (pop),
        .PopData  (headEntry),
        .Full     (fifoFull),
        .Empty    (fifoEmpty)
    );

    logic             dropEvent, errEvent;
    logic [CNT_W-1:0] errCountD;
    logic             overrunD;

    assign dropEvent = RxDone && fifoFull && !pop;
    assign errEvent  = RxDone && hasError(RxError);

    // Events take precedence over a coincident clear.
    always_comb begin
        errCountD = ErrCount;
        if (errEvent) begin
            if (ClearStatus)          errCountD = {{(CNT_W-1){1'b0}}, 1'b1};
            else if (ErrCount != '1)  errCountD = ErrCount + 1'b1;
        end else if (ClearStatus) begin
            errCountD = '0;
        end
        overrunD = Overrun;
        if (dropEvent)        overrunD = 1'b1;
        else if (ClearStatus) overrunD = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            ErrCount <= '0;
            Overrun  <= 1'b0;
        end else begin
            ErrCount <= errCountD;
            Overrun  <= overrunD;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised and directed bench for uart_rx_ctrl against a queue-based model;
// a second instance with a 2-bit error counter exercises saturation.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SatMax = 3;
    localparam int unsigned WideMax = 255;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       CfgWrite = 1'b0;
    logic [1:0] CfgBaud = '0;
    logic [1:0] CfgParity = '0;
    logic       RxActive = 1'b0;
    logic       RxDone = 1'b0;
    logic [7:0] RxData = '0;
    logic [2:0] RxError = '0;
    logic       OutReady = 1'b0;
    logic       ClearStatus = 1'b0;

    logic       CfgBusy, OutValid, Overrun;
    logic [1:0] BaudRate, ParityType;
    logic [7:0] OutData;
    logic [2:0] OutError;
    logic [7:0] ErrCount;

    logic       satCfgBusy, satOutValid, satOverrun;
    logic [1:0] satBaud, satParity;
    logic [7:0] satOutData;
    logic [2:0] satOutError;
    logic [1:0] satErrCount;

    always #5 Clock = ~Clock;

    uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .Clock(Clock), .ResetN(ResetN), .CfgWrite(CfgWrite), .CfgBaud(CfgBaud),
        .CfgParity(CfgParity), .CfgBusy(CfgBusy), .BaudRate(BaudRate),
        .ParityType(ParityType), .RxActive(RxActive), .RxDone(RxDone), .RxData(RxData),
        .RxError(RxError), .OutValid(OutValid), .OutData(OutData), .OutError(OutError),
        .OutReady(OutReady), .Overrun(Overrun), .ErrCount(ErrCount),
        .ClearStatus(ClearStatus)
    );

    uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) dutSat (
        .Clock(Clock), .ResetN(ResetN), .CfgWrite(CfgWrite), .CfgBaud(CfgBaud),
        .CfgParity(CfgParity), .CfgBusy(satCfgBusy), .BaudRate(satBaud),
        .ParityType(satParity), .RxActive(RxActive), .RxDone(RxDone), .RxData(RxData),
        .RxError(RxError), .OutValid(satOutValid), .OutData(satOutData),
        .OutError(satOutError), .OutReady(OutReady), .Overrun(satOverrun),
        .ErrCount(satErrCount), .ClearStatus(ClearStatus)
    );

    int nChecks = 0;
    int nBad = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frames as a queue, config as a pending-request flag.
    logic [10:0] mq[$];
    bit          mPending;
    logic [3:0]  mShadow;
    logic [1:0]  mBaud, mParity;
    bit          mOverrun;
    int          mErr, mErrSat;

    task automatic modelUpdate();
        bit doPop, drop, errEv;
        if (!ResetN) begin
            mq.delete();
            mPending = 0; mShadow = '0;
            mBaud = 2'b00; mParity = 2'b00;
            mOverrun = 0; mErr = 0; mErrSat = 0;
            return;
        end
        doPop = (mq.size() != 0) && OutReady;
        drop  = RxDone && (mq.size() == DEPTH) && !doPop;
        errEv = RxDone && (RxError != 3'b000);
        if (doPop) void'(mq.pop_front());
        if (RxDone && !drop) mq.push_back({RxError, RxData});
        if (CfgWrite) begin
            mShadow = {CfgBaud, CfgParity};
            mPending = 1;
        end else if (mPending && !RxActive && !RxDone) begin
            mBaud = mShadow[3:2]; mParity = mShadow[1:0];
            mPending = 0;
        end
        if (drop) mOverrun = 1;
        else if (ClearStatus) mOverrun = 0;
        if (errEv) begin
            mErr    = ClearStatus ? 1 : ((mErr < WideMax) ? mErr + 1 : WideMax);
            mErrSat = ClearStatus ? 1 : ((mErrSat < SatMax) ? mErrSat + 1 : SatMax);
        end else if (ClearStatus) begin
            mErr = 0; mErrSat = 0;
        end
    endtask

    task automatic compareAll();
        logic [10:0] head;
        head = (mq.size() != 0) ? mq[0] : 11'd0;
        checkVal("OutValid", OutValid, mq.size() != 0);
        checkVal("OutData", OutData, head[7:0]);
        checkVal("OutError", OutError, head[10:8]);
        checkVal("CfgBusy", CfgBusy, mPending);
        checkVal("BaudRate", BaudRate, mBaud);
        checkVal("ParityType", ParityType, mParity);
        checkVal("Overrun", Overrun, mOverrun);
        checkVal("ErrCount", ErrCount, mErr);
        checkVal("satErrCount", satErrCount, mErrSat);
        checkVal("satOverrun", satOverrun, mOverrun);
    endtask

    task automatic step();
        @(posedge Clock);
        modelUpdate();
        #1;
        compareAll();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame(input logic [7:0] d, input logic [2:0] e);
        RxDone = 1'b1; RxData = d; RxError = e;
        step();
        RxDone = 1'b0; RxError = '0;
    endtask

    task automatic cfgWrite(input logic [1:0] b, input logic [1:0] p);
        CfgWrite = 1'b1; CfgBaud = b; CfgParity = p;
        step();
        CfgWrite = 1'b0;
    endtask

    initial begin
        steps(2);
        ResetN = 1'b1;
        checkVal("rstValid", OutValid, 1'b0);
        checkVal("rstBaud", BaudRate, 2'b00);
        checkVal("rstErr", ErrCount, 8'd0);

        // Config change on an idle line.
        cfgWrite(2'b10, 2'b01);
        checkVal("cfgBusyOne", CfgBusy, 1'b1);
        step();
        checkVal("cfgBaudNew", BaudRate, 2'b10);
        checkVal("cfgParityNew", ParityType, 2'b01);
        checkVal("cfgBusyDone", CfgBusy, 1'b0);

        // Config change held off by an active frame; last request wins.
        RxActive = 1'b1;
        cfgWrite(2'b11, 2'b10);
        steps(50);
        checkVal("cfgHeldBaud", BaudRate, 2'b10);
        cfgWrite(2'b01, 2'b00);
        steps(3);
        checkVal("cfgHeldBusy", CfgBusy, 1'b1);
        RxActive = 1'b0;
        steps(2);
        checkVal("cfgFinalBaud", BaudRate, 2'b01);
        checkVal("cfgFinalParity", ParityType, 2'b00);

        // Two frames with a stalled consumer, then drain.
        OutReady = 1'b0;
        frame(8'hA5, 3'b000);
        frame(8'h3C, 3'b000);
        steps(3);
        checkVal("holdData", OutData, 8'hA5);
        OutReady = 1'b1;
        step();
        checkVal("secondHead", OutData, 8'h3C);
        step();
        checkVal("drainedValid", OutValid, 1'b0);
        OutReady = 1'b0;

        // Overflow: fifth frame dropped.
        for (int i = 0; i < 5; i++) frame(8'h10 + 8'(i), 3'b000);
        checkVal("overrunSet", Overrun, 1'b1);
        OutReady = 1'b1;
        steps(6);
        OutReady = 1'b0;
        ClearStatus = 1'b1; step(); ClearStatus = 1'b0;

        // Full with simultaneous push and pop: no drop.
        for (int i = 0; i < 4; i++) frame(8'h20 + 8'(i), 3'b000);
        OutReady = 1'b1;
        frame(8'h2F, 3'b000);
        checkVal("fullPushPop", Overrun, 1'b0);
        steps(6);
        OutReady = 1'b0;

        // Error frames, error flags preserved per entry.
        ClearStatus = 1'b1; step(); ClearStatus = 1'b0;
        frame(8'h01, 3'b001); frame(8'h02, 3'b001);
        frame(8'h03, 3'b000); frame(8'h04, 3'b001);
        checkVal("errThree", ErrCount, 8'd3);
        checkVal("errHeadFlag", OutError, 3'b001);
        OutReady = 1'b1; steps(6); OutReady = 1'b0;
        ClearStatus = 1'b1;
        frame(8'h05, 3'b100);
        ClearStatus = 1'b0;
        checkVal("clearVsErr", ErrCount, 8'd1);

        // Saturation of the 2-bit counter.
        OutReady = 1'b1;
        for (int i = 0; i < 5; i++) frame(8'h40 + 8'(i), 3'b010);
        checkVal("satCount", satErrCount, 2'd3);

        // Reset mid-frame with FIFO contents and a pending request.
        OutReady = 1'b0; RxActive = 1'b1;
        frame(8'h77, 3'b000); frame(8'h78, 3'b000);
        cfgWrite(2'b11, 2'b11);
        ResetN = 1'b0; step(); ResetN = 1'b1; RxActive = 1'b0;
        checkVal("rstMidValid", OutValid, 1'b0);
        checkVal("rstMidBusy", CfgBusy, 1'b0);
        checkVal("rstMidBaud", BaudRate, 2'b00);
        checkVal("rstMidOverrun", Overrun, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ResetN      = ($urandom_range(0, 299) != 0);
            RxActive    = ($urandom_range(0, 3) != 0);
            RxDone      = ($urandom_range(0, 2) == 0);
            RxData      = 8'($urandom);
            RxError     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            OutReady    = ($urandom_range(0, 2) == 0);
            CfgWrite    = ($urandom_range(0, 9) == 0);
            CfgBaud     = 2'($urandom);
            CfgParity   = 2'($urandom_range(0, 2));
            ClearStatus = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
